// File: rtl/dmem_responder.sv
// Data-memory responder: memory end of the core load/store port.
// Serves one request at a time. It applies byte/half/word lane placement on
// stores, returns right-justified load data, and inserts WAIT_CYCLES of
// latency between accept and response.
module dmem_responder #(
  parameter int unsigned DEPTH       = 64,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_2000,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] SPAN      = 32'(DEPTH * 4);
  localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, stateNext;
  logic [3:0]  cnt, cntNext;
  logic        accept, enterResp;

  logic        latWe;
  logic [31:0] latAddr, latWdata;
  logic [1:0]  latSize;

  logic [31:0] mem [DEPTH];

  logic             curWe, curErr;
  logic [31:0]      curAddr, curWdata, off;
  logic [1:0]       curSize, lane;
  logic [IDX_W-1:0] wordIdx;
  logic [3:0]       byteEn;
  logic [31:0]      laneData, shifted, loadData;

  assign rsp_valid = (state == RESP);

  // State and wait counter register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  // Next-state logic, accept handshake and RESP-entry strobe
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    enterResp = 1'b0;
    req_ready = (state == IDLE);
    accept    = req_ready && req_valid;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (WAIT_CYCLES == 0) begin
            stateNext = RESP;
            enterResp = 1'b1;
          end else begin
            stateNext = WAIT;
            cntNext   = WAIT_LOAD;
          end
        end
      end
      WAIT: begin
        cntNext = cnt - 4'd1;
        if (cnt == 4'd1) begin
          stateNext = RESP;
          enterResp = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Capture the request on accept
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      latWe    <= 1'b0;
      latAddr  <= '0;
      latWdata <= '0;
      latSize  <= '0;
    end else if (accept) begin
      latWe    <= req_we;
      latAddr  <= req_addr;
      latWdata <= req_wdata;
      latSize  <= req_size;
    end
  end

  // Decode address, errors, lane enables and load alignment.
  // In IDLE the live request is used, so the zero-wait path can commit on the
  // accept edge itself, before the latched copy exists.
  always_comb begin
    curWe    = (state == IDLE) ? req_we    : latWe;
    curAddr  = (state == IDLE) ? req_addr  : latAddr;
    curWdata = (state == IDLE) ? req_wdata : latWdata;
    curSize  = (state == IDLE) ? req_size  : latSize;
    off      = curAddr - BASE_ADDR;
    lane     = off[1:0];
    wordIdx  = off[IDX_W+1:2];
    curErr   = (curAddr < BASE_ADDR) || (off >= SPAN) || (curSize == 2'b11) ||
               ((curSize == 2'b01) && off[0]) ||
               ((curSize == 2'b10) && (lane != 2'b00));
    byteEn   = '0;
    laneData = curWdata;
    case (curSize)
      2'b00: begin
        byteEn   = 4'b0001 << lane;
        laneData = {4{curWdata[7:0]}};
      end
      2'b01: begin
        byteEn   = off[1] ? 4'b1100 : 4'b0011;
        laneData = {2{curWdata[15:0]}};
      end
      2'b10:   byteEn = '1;
      default: byteEn = '0;
    endcase
    shifted = mem[wordIdx] >> {lane, 3'b000};
    case (curSize)
      2'b00:   loadData = {24'b0, shifted[7:0]};
      2'b01:   loadData = {16'b0, shifted[15:0]};
      default: loadData = shifted;
    endcase
  end

  // Commit stores on the edge entering RESP; array is not reset
  always_ff @(posedge clk) begin
    if (enterResp && curWe && !curErr) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (byteEn[b]) mem[wordIdx][8*b +: 8] <= laneData[8*b +: 8];
      end
    end
  end

  // Register response data/error on the edge entering RESP
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (enterResp) begin
      rsp_err   <= curErr;
      rsp_rdata <= (curWe || curErr) ? '0 : loadData;
    end
  end

endmodule
